sipo_frame_arbiter: RTL and testbench

- Shares one byte-to-word serial-in/parallel-out packer between NREQ byte-stream requesters.
- Grants the packer to one requester for a whole frame of BYTES bytes, using round-robin order.
- Presents the packed word with a source tag, holds it until a downstream acknowledge, then re-arbitrates.
- Sits between per-channel byte sources and the word-wide consumer.

---
 rtl/sipo_frame_arbiter_pkg.sv | 21 ++
 rtl/sipo_frame_arbiter_rr.sv | 38 +++
 rtl/sipo_frame_arbiter.sv | 134 +++++++++++++
 tb/tb_sipo_frame_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_frame_arbiter_pkg.sv
// Shared types and constants for the round-robin byte-to-word frame packer.
// Holds the FSM encoding, default geometry and the source-index width helper.
package sipo_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_BW      = 8;
  localparam int DEF_BYTES   = 8;
  localparam int DEF_TIMEOUT = 16;

  // A single requester still needs a one-bit source tag.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sipo_frame_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around, returned as both a one-hot grant and an index.
module rr_arbiter
  import sipo_frame_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = src_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic          found;
  logic [IW-1:0] cand;

  assign any = |req;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sipo_frame_arbiter.sv
// Shares one byte-to-word packer between NREQ byte streams: a frame is granted
// round-robin, packed MSB-first, held with its source tag until acknowledged.
module sipo_frame_arbiter
  import sipo_frame_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int BW      = DEF_BW,
  parameter int BYTES   = DEF_BYTES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*BW-1:0]           req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic [BYTES*BW-1:0]          out_word,
  output logic [src_width(NREQ)-1:0]   out_src,
  output logic                         out_valid,
  input  logic                         out_ack,
  output logic                         err_timeout
);

  localparam int SW = src_width(NREQ);
  localparam int WW = BYTES * BW;
  localparam int CW = $clog2(BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          state, state_nxt;
  logic [SW-1:0]   owner, ptr, gnt_idx, owner_inc;
  logic [NREQ-1:0] owner_oh, gnt_vec;
  logic            gnt_any;
  logic [WW-1:0]   shift_reg, shift_nxt;
  logic [CW-1:0]   count;
  logic [TW-1:0]   idle_cnt;
  logic [BW-1:0]   owner_byte;
  logic            xfer, frame_done, abort;

  rr_arbiter #(.NREQ(NREQ), .IW(SW)) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(gnt_vec),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  assign owner_byte = req_data[int'(owner)*BW +: BW];
  assign shift_nxt  = {shift_reg[WW-BW-1:0], owner_byte};
  assign owner_inc  = (owner == SW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign out_valid  = (state == ST_HOLD);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    xfer       = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: if (gnt_any) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        req_ready = owner_oh;
        xfer      = |(req_valid & owner_oh);
        if (xfer && count == CW'(BYTES - 1)) begin
          frame_done = 1'b1;
          state_nxt  = ST_HOLD;
        end else if (!xfer && idle_cnt == TW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: if (out_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= '0;
      owner_oh    <= '0;
      ptr         <= '0;
      shift_reg   <= '0;
      count       <= '0;
      idle_cnt    <= '0;
      out_word    <= '0;
      out_src     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= abort;
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (gnt_any) begin
            owner    <= gnt_idx;
            owner_oh <= gnt_vec;
          end
        end
        ST_SHIFT: begin
          if (xfer) begin
            shift_reg <= shift_nxt;
            count     <= count + CW'(1);
            idle_cnt  <= '0;
            if (frame_done) begin
              out_word <= shift_nxt;
              out_src  <= owner;
            end
          end else if (abort) begin
            // Partial frame is dropped; out_word keeps the last good frame.
            shift_reg <= '0;
            count     <= '0;
            idle_cnt  <= '0;
            ptr       <= owner_inc;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        ST_HOLD: begin
          if (out_ack) begin
            ptr       <= owner_inc;
            count     <= '0;
            shift_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_arbiter.sv
// Scoreboard bench for sipo_frame_arbiter: per-lane byte sources, expected
// frames queued at stimulus time and compared when out_valid rises.
module tb_sipo_frame_arbiter;

  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int BYTES = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [63:0] out_word;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ack;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [4][64];
  int          head [4];
  int          tail [4];
  bit          tog  [4];
  bit          phase = 1'b0;
  logic [3:0]  hs;

  logic [63:0] exp_word_q [$];
  logic [1:0]  exp_src_q  [$];

  bit    seen = 1'b0;
  int    hold_len = 0;
  bit    chk_hold1 = 1'b1;
  bit    chk_onehot = 1'b0;
  int    err_cnt = 0;
  int    idle_seen = 0;

  sipo_frame_arbiter #(.NREQ(NREQ), .BW(BW), .BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_word   (out_word),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
      tog[i]  = 1'b0;
    end
    req_valid = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_lanes();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_byte(input int lane, input logic [7:0] b);
    mem[lane][tail[lane]] = b;
    tail[lane]++;
  endtask

  task automatic send_frame(input int lane, input logic [63:0] w, input bit expect_out);
    for (int k = 0; k < BYTES; k++) push_byte(lane, w[63-8*k -: 8]);
    if (expect_out) begin
      exp_word_q.push_back(w);
      exp_src_q.push_back(2'(lane));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_word_q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) check("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Lane sources: a handshake seen before the edge advances that lane.
  initial begin
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      phase = ~phase;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) head[i]++;
        req_valid[i] = (head[i] < tail[i]) && (!tog[i] || phase);
        req_data[i*8 +: 8] = mem[i][head[i] & 63];
      end
    end
  end

  // Output monitor and scoreboard.
  initial begin
    logic [63:0] ew;
    logic [1:0]  es;
    forever begin
      @(negedge clk);
      if (err_timeout) err_cnt++;
      if ((req_ready & ~req_valid) != 0) idle_seen++;
      if (chk_onehot && req_ready != 0)
        check("rdy_onehot", 64'($onehot(req_ready)), 64'd1);
      if (out_valid) begin
        hold_len++;
        if (!seen) begin
          seen = 1'b1;
          if (exp_word_q.size() == 0) begin
            check("unexpected_frame", 64'd1, 64'd0);
          end else begin
            ew = exp_word_q.pop_front();
            es = exp_src_q.pop_front();
            check("out_word", out_word, ew);
            check("out_src", 64'(out_src), 64'(es));
          end
        end
      end else begin
        if (hold_len > 0 && chk_hold1) check("hold_len", 64'(hold_len), 64'd1);
        hold_len = 0;
        seen     = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    int n;
    out_ack = 1'b1;
    clear_lanes();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_out_word", out_word, 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single requester, back-to-back bytes, ack tied high.
    send_frame(0, 64'h0102030405060708, 1'b1);
    drain();

    // Two contending requesters: expected order 0, 2, 0.
    do_reset();
    chk_onehot = 1'b1;
    send_frame(0, 64'hA0A1A2A3A4A5A6A7, 1'b1);
    send_frame(2, 64'hB0B1B2B3B4B5B6B7, 1'b1);
    send_frame(0, 64'hC0C1C2C3C4C5C6C7, 1'b1);
    drain();
    chk_onehot = 1'b0;

    // Mid-frame stall on requester 1 until the frame is aborted.
    do_reset();
    idle_seen = 0;
    err_cnt   = 0;
    push_byte(1, 8'h11);
    push_byte(1, 8'h12);
    push_byte(1, 8'h13);
    n = 0;
    while (err_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("err_wait_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    check("err_pulses", 64'(err_cnt), 64'd1);
    check("idle_cycles", 64'(idle_seen), 64'(TIMEOUT));
    check("abort_ready", 64'(req_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_word", out_word, 64'd0);
    send_frame(2, 64'h2122232425262728, 1'b1);
    send_frame(1, 64'h3132333435363738, 1'b1);
    drain();

    // Back-pressure: ack held low for 10 cycles after the frame lands.
    err_cnt   = 0;
    chk_hold1 = 1'b0;
    out_ack   = 1'b0;
    w = {$urandom, $urandom};
    send_frame(0, w, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (n >= 100) check("hold_wait_timeout", 64'd0, 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_word", out_word, w);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ack = 1'b1;
    @(posedge clk);
    #1 out_ack = 1'b0;
    @(negedge clk);
    check("ack_drop", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk_hold1 = 1'b1;
    out_ack   = 1'b1;

    // Asynchronous reset after four bytes from requester 3.
    for (int k = 0; k < BYTES; k++) push_byte(3, 8'(8'hF0 + k));
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (head[3] < 4 && n < 100);
    if (n >= 100) check("rst_wait_timeout", 64'd0, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    check("arst_out_word", out_word, 64'd0);
    check("arst_out_src", 64'(out_src), 64'd0);
    check("arst_err", 64'(err_timeout), 64'd0);
    clear_lanes();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    w = {$urandom, $urandom};
    send_frame(3, w, 1'b1);
    drain();

    // Owner valid toggles every cycle; gaps stay well below the timeout.
    tog[0] = 1'b1;
    w = {$urandom, $urandom};
    send_frame(0, w, 1'b1);
    drain();
    tog[0] = 1'b0;
    check("no_spurious_err", 64'(err_cnt), 64'd0);
    check("sb_empty", 64'(exp_word_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
